// File: rtl/sequential_alu_pkg.sv
// rtl/sequential_alu_pkg.sv - shared op codes, FSM states and range helpers for the sequential ALU
package sequential_alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_REM = 3'd4;

    // Engine mode select for the iterative core
    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Largest positive two's-complement value of the given width
    function automatic logic [63:0] max_of(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Bit pattern of the most negative two's-complement value of the given width
    function automatic logic [63:0] min_of(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/seq_muldiv_core.sv
// rtl/seq_muldiv_core.sv - unsigned one-bit-per-cycle shift-add multiplier / restoring divider
module seq_muldiv_core
    import sequential_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic                      mode_i,
    input  logic [DATA_WIDTH-1:0]     a_i,
    input  logic [DATA_WIDTH-1:0]     b_i,
    output logic                      done_o,
    output logic [2*DATA_WIDTH-1:0]   prod_o,
    output logic [DATA_WIDTH-1:0]     quot_o,
    output logic [DATA_WIDTH-1:0]     rem_o
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    // p_q holds {accumulator, multiplier} for MUL and {partial remainder, quotient} for DIV
    logic [2*W-1:0] p_q;
    logic [W-1:0]   m_q;
    logic [CW-1:0]  cnt_q;
    logic           mode_q;
    logic           busy_q;

    logic [W:0]     mul_sum;
    logic [W:0]     div_shift;
    logic [W:0]     div_diff;
    logic [2*W-1:0] step_d;

    // One iteration of either algorithm, selected by the latched mode
    always_comb begin
        mul_sum   = {1'b0, p_q[2*W-1:W]} + (p_q[0] ? {1'b0, m_q} : '0);
        div_shift = {p_q[2*W-1:W], p_q[W-1]};
        div_diff  = div_shift - {1'b0, m_q};
        if (mode_q == MODE_MUL) begin
            step_d = {mul_sum, p_q[W-1:1]};
        end else if (div_shift >= {1'b0, m_q}) begin
            step_d = {div_diff[W-1:0], p_q[W-2:0], 1'b1};
        end else begin
            step_d = {div_shift[W-1:0], p_q[W-2:0], 1'b0};
        end
    end

    // Load operands on start, then iterate DATA_WIDTH times
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            p_q    <= '0;
            m_q    <= '0;
            cnt_q  <= '0;
            mode_q <= MODE_MUL;
            busy_q <= 1'b0;
        end else if (start_i) begin
            p_q    <= (mode_i == MODE_MUL) ? {{W{1'b0}}, b_i} : {{W{1'b0}}, a_i};
            m_q    <= (mode_i == MODE_MUL) ? a_i : b_i;
            cnt_q  <= '0;
            mode_q <= mode_i;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            p_q   <= step_d;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == LAST) begin
                busy_q <= 1'b0;
            end
        end
    end

    // High during the cycle whose closing edge performs the final iteration
    assign done_o = busy_q && (cnt_q == LAST);
    assign prod_o = p_q;
    assign quot_o = p_q[W-1:0];
    assign rem_o  = p_q[2*W-1:W];

endmodule

// File: rtl/sequential_alu_hs.sv
// rtl/sequential_alu_hs.sv - handshaked signed ALU; SEQUENTIAL_ALU_HS_SAT_EN selects saturating overflow results
module sequential_alu_hs
    import sequential_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [2:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_q,
    output logic                  o_ovf,
    output logic                  o_zero,
    output logic                  o_dbz
);

    localparam int W = DATA_WIDTH;
    localparam logic [W-1:0] MAX_V = W'(max_of(W));
    localparam logic [W-1:0] MIN_V = W'(min_of(W));
`ifdef SEQUENTIAL_ALU_HS_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    state_e         state_q;
    logic [2:0]     op_q;
    logic           sa_q, sb_q, a_min_q, b_m1_q, b_zero_q;
    logic           ready_q, valid_q, ovf_q, zero_q, dbz_q;
    logic [W-1:0]   q_q;

    logic           accept, is_muldiv;
    logic [W-1:0]   mag_a, mag_b;
    logic           core_done;
    logic [2*W-1:0] core_prod;
    logic [W-1:0]   core_quot, core_rem;

    logic [W:0]     as_sum;
    logic [W-1:0]   imm_q_d;
    logic           imm_ovf_d;

    logic           neg;
    logic [2*W-1:0] prod_s;
    logic [W-1:0]   fix_q_d, sat_v;
    logic           fix_ovf_d, fix_dbz_d;

    assign accept    = i_valid && ready_q;
    assign is_muldiv = (i_op == OP_MUL) || (i_op == OP_DIV) || (i_op == OP_REM);
    assign mag_a     = i_a[W-1] ? -i_a : i_a;
    assign mag_b     = i_b[W-1] ? -i_b : i_b;

    seq_muldiv_core #(.DATA_WIDTH(W)) u_core (
        .clk_i   (i_clk),
        .rst_ni  (i_nrst),
        .start_i (accept && is_muldiv),
        .mode_i  ((i_op == OP_MUL) ? MODE_MUL : MODE_DIV),
        .a_i     (mag_a),
        .b_i     (mag_b),
        .done_o  (core_done),
        .prod_o  (core_prod),
        .quot_o  (core_quot),
        .rem_o   (core_rem)
    );

    // Single-cycle ADD/SUB and reserved-op results, evaluated from the live request
    always_comb begin
        if (i_op == OP_SUB) begin
            as_sum = {i_a[W-1], i_a} - {i_b[W-1], i_b};
        end else begin
            as_sum = {i_a[W-1], i_a} + {i_b[W-1], i_b};
        end
        imm_q_d   = as_sum[W-1:0];
        imm_ovf_d = as_sum[W] ^ as_sum[W-1];
        if (SAT_EN && imm_ovf_d) begin
            imm_q_d = as_sum[W] ? MIN_V : MAX_V;
        end
        if ((i_op != OP_ADD) && (i_op != OP_SUB)) begin
            imm_q_d   = '0;
            imm_ovf_d = 1'b1;
        end
    end

    // Sign restoration and overflow judgement applied to the unsigned core results
    always_comb begin
        neg       = sa_q ^ sb_q;
        prod_s    = neg ? -core_prod : core_prod;
        fix_q_d   = '0;
        fix_ovf_d = 1'b0;
        fix_dbz_d = 1'b0;
        sat_v     = MAX_V;
        case (op_q)
            OP_MUL: begin
                fix_q_d   = prod_s[W-1:0];
                fix_ovf_d = neg ? (core_prod > {{W{1'b0}}, MIN_V})
                                : (core_prod > {{W{1'b0}}, MAX_V});
                sat_v     = neg ? MIN_V : MAX_V;
            end
            OP_DIV, OP_REM: begin
                if (b_zero_q) begin
                    fix_ovf_d = 1'b1;
                    fix_dbz_d = 1'b1;
                    sat_v     = sa_q ? MIN_V : MAX_V;
                end else if (op_q == OP_DIV) begin
                    fix_q_d   = neg ? -core_quot : core_quot;
                    fix_ovf_d = a_min_q && b_m1_q;
                end else begin
                    fix_q_d   = sa_q ? -core_rem : core_rem;
                end
            end
            default: begin
                fix_q_d = '0;
            end
        endcase
        if (SAT_EN && fix_ovf_d) begin
            fix_q_d = sat_v;
        end
    end

    // Handshake FSM with registered result and flag outputs
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            q_q      <= '0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            dbz_q    <= 1'b0;
            op_q     <= OP_ADD;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            a_min_q  <= 1'b0;
            b_m1_q   <= 1'b0;
            b_zero_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q     <= i_op;
                        sa_q     <= i_a[W-1];
                        sb_q     <= i_b[W-1];
                        a_min_q  <= (i_a == MIN_V);
                        b_m1_q   <= (i_b == '1);
                        b_zero_q <= (i_b == '0);
                        ready_q  <= 1'b0;
                        if (is_muldiv) begin
                            state_q <= ST_BUSY;
                        end else begin
                            state_q <= ST_DONE;
                            valid_q <= 1'b1;
                            q_q     <= imm_q_d;
                            ovf_q   <= imm_ovf_d;
                            zero_q  <= (imm_q_d == '0);
                            dbz_q   <= 1'b0;
                        end
                    end
                end
                ST_BUSY: begin
                    if (core_done) begin
                        state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    state_q <= ST_DONE;
                    valid_q <= 1'b1;
                    q_q     <= fix_q_d;
                    ovf_q   <= fix_ovf_d;
                    zero_q  <= (fix_q_d == '0);
                    dbz_q   <= fix_dbz_d;
                end
                ST_DONE: begin
                    if (i_ready) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_ready = ready_q;
    assign o_valid = valid_q;
    assign o_q     = q_q;
    assign o_ovf   = ovf_q;
    assign o_zero  = zero_q;
    assign o_dbz   = dbz_q;

endmodule

// File: tb/tb_sequential_alu_hs.sv
// tb/tb_sequential_alu_hs.sv - scoreboard bench for sequential_alu_hs against a signed arithmetic model
module tb_sequential_alu_hs;

    localparam int W = 8;

    logic         i_clk = 1'b0;
    logic         i_nrst, i_valid, i_ready;
    logic         o_ready, o_valid, o_ovf, o_zero, o_dbz;
    logic [2:0]   i_op;
    logic [W-1:0] i_a, i_b, o_q;

    typedef struct {
        logic [W-1:0] q;
        bit           ovf;
        bit           dbz;
        bit           zero;
        int           lat_post;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    bit   busy_m = 1'b0;
    int   acc_cyc = 0;
    logic [W-1:0] corners [6] = '{8'h00, 8'h01, 8'hFF, 8'h80, 8'h7F, 8'h02};

    sequential_alu_hs #(.DATA_WIDTH(W)) dut (
        .i_clk   (i_clk),
        .i_nrst  (i_nrst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_op    (i_op),
        .i_a     (i_a),
        .i_b     (i_b),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_q     (o_q),
        .o_ovf   (o_ovf),
        .o_zero  (o_zero),
        .o_dbz   (o_dbz)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Signed reference: plain integer arithmetic on the operand values
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] au, input logic [W-1:0] bu);
        exp_t   e;
        longint a, b, r, maxl, minl;
        bit     bad_op, dbz;
        a = longint'($signed(au));
        b = longint'($signed(bu));
        maxl = (longint'(1) <<< (W - 1)) - 1;
        minl = -maxl - 1;
        r = 0; bad_op = 0; dbz = 0;
        case (op)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a * b;
            3'd3: if (b == 0) dbz = 1; else r = a / b;
            3'd4: if (b == 0) dbz = 1; else r = a % b;
            default: bad_op = 1;
        endcase
        e.ovf = bad_op || dbz || (r > maxl) || (r < minl);
        e.dbz = dbz;
        e.q   = r[W-1:0];
`ifdef SEQUENTIAL_ALU_HS_SAT_EN
        if (e.ovf) begin
            if (bad_op)   e.q = '0;
            else if (dbz) e.q = (a >= 0) ? W'(maxl) : W'(minl);
            else          e.q = (r > maxl) ? W'(maxl) : W'(minl);
        end
`endif
        e.zero = (e.q == '0);
        e.lat_post = (op >= 3'd2 && op <= 3'd4) ? W + 1 : 0;
        return e;
    endfunction

    // Monitor: checks handshake timing and pops the scoreboard on each consumed result
    always @(negedge i_clk) begin
        #3;
        if (!mon_en) begin
            busy_m = 1'b0;
        end else begin
            bit ev;
            ev = busy_m && (sb.size() > 0) && ((cyc - acc_cyc) >= sb[0].lat_post);
            chk("o_ready", o_ready, !busy_m);
            chk("o_valid", o_valid, ev);
            if (ev) begin
                chk("o_q", o_q, sb[0].q);
                chk("o_ovf", o_ovf, sb[0].ovf);
                chk("o_dbz", o_dbz, sb[0].dbz);
                chk("o_zero", o_zero, sb[0].zero);
            end
            if (ev && i_ready) begin
                void'(sb.pop_front());
                busy_m = 1'b0;
            end else if (!busy_m && i_valid) begin
                busy_m = 1'b1;
                acc_cyc = cyc + 1;
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        @(negedge i_clk);
        while (!o_ready && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        chk("send_ready", o_ready, 1);
        if (o_ready) begin
            i_valid = 1'b1; i_op = op; i_a = a; i_b = b;
            sb.push_back(model(op, a, b));
            @(negedge i_clk);
        end
        i_valid = 1'b0; i_op = 3'($urandom); i_a = W'($urandom); i_b = W'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge i_clk);
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    function automatic logic [W-1:0] rand_opnd();
        if ($urandom_range(3) == 0) return corners[$urandom_range(5)];
        return W'($urandom);
    endfunction

    initial begin
        int n;
        int r;
        i_nrst = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_op = '0; i_a = '0; i_b = '0;
        repeat (3) @(negedge i_clk);
        chk("rst_ready", o_ready, 1);
        chk("rst_valid", o_valid, 0);
        chk("rst_q", o_q, 0);
        chk("rst_flags", {o_ovf, o_zero, o_dbz}, 0);
        i_nrst = 1'b1;
        mon_en = 1'b1;

        send(3'd0, W'(100), W'(27));
        send(3'd0, W'(100), W'(28));
        send(3'd1, W'(0), W'(-128));
        send(3'd1, W'(-100), W'(28));
        send(3'd2, W'(-16), W'(8));
        send(3'd2, W'(16), W'(8));
        send(3'd2, W'(0), W'(-5));
        send(3'd2, W'(-128), W'(-1));
        send(3'd3, W'(-7), W'(2));
        send(3'd4, W'(-7), W'(2));
        send(3'd3, W'(-128), W'(-1));
        send(3'd4, W'(-128), W'(-1));
        send(3'd3, W'(5), W'(0));
        send(3'd4, W'(-5), W'(0));
        send(3'd6, W'(3), W'(4));
        wait_idle();

        // Backpressure: result must hold while the consumer stalls
        i_ready = 1'b0;
        send(3'd2, W'(3), W'(-5));
        n = 0;
        while (!o_valid && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        chk("bp_valid_seen", o_valid, 1);
        repeat (5) @(negedge i_clk);
        i_ready = 1'b1;
        wait_idle();
        repeat (2) @(negedge i_clk);

        // Asynchronous reset in the middle of a multiply
        mon_en = 1'b0;
        i_valid = 1'b1; i_op = 3'd2; i_a = W'(7); i_b = W'(9);
        @(negedge i_clk);
        i_valid = 1'b0;
        chk("mul_busy_ready", o_ready, 0);
        repeat (4) @(posedge i_clk);
        #2 i_nrst = 1'b0;
        #1;
        chk("arst_ready", o_ready, 1);
        chk("arst_valid", o_valid, 0);
        chk("arst_q", o_q, 0);
        chk("arst_flags", {o_ovf, o_zero, o_dbz}, 0);
        @(negedge i_clk);
        i_nrst = 1'b1;
        mon_en = 1'b1;
        send(3'd0, W'(1), W'(1));
        repeat (15) @(negedge i_clk);
        wait_idle();

        // Randomised traffic with random request and consumer stalls
        for (int c = 0; c < 20000; c++) begin
            @(negedge i_clk);
            i_ready = ($urandom_range(3) != 0);
            i_valid = $urandom_range(1);
            r = $urandom_range(9);
            i_op = (r < 8) ? 3'(r % 5) : 3'(5 + $urandom_range(2));
            i_a = rand_opnd();
            i_b = rand_opnd();
            if (i_valid && o_ready) sb.push_back(model(i_op, i_a, i_b));
        end
        @(negedge i_clk);
        i_valid = 1'b0;
        i_ready = 1'b1;
        wait_idle();
        repeat (3) @(negedge i_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #(10 * 60000);
        errors++;
        $display("FAIL watchdog: cycle %0d reached, expected finish before 60000", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
